// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer crossings: Gray/binary conversion
// and the multi-bit-change test used by the pointer synchronisers.
package async_fifo_pkg;

    localparam int PTR_MAX_W           = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int PTR_WIDTH_DEFAULT   = 5;

    // Low w bits set; used to ignore anything above the active pointer width.
    function automatic logic [PTR_MAX_W-1:0] width_mask(input int unsigned w);
        logic [PTR_MAX_W-1:0] m;
        if (w >= PTR_MAX_W)
            m = '1;
        else
            m = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
        return m;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                      input int unsigned w);
        logic [PTR_MAX_W-1:0] gm;
        logic [PTR_MAX_W-1:0] b;
        gm = g & width_mask(w);
        b  = '0;
        b[PTR_MAX_W-1] = gm[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ gm[i];
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                      input int unsigned w);
        logic [PTR_MAX_W-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [PTR_MAX_W-1:0] x);
        return (x & (x - PTR_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser with asynchronous active-low reset; also used
// as a single-bit control synchroniser with WIDTH=1.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++)
                s[i] <= '0;
        end else begin
            s[0] <= d;
            for (int i = 1; i < STAGES; i++)
                s[i] <= s[i-1];
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Gray pointer synchroniser for the async FIFO: flop chain into clk, then a
// registered stage giving binary value, advance, change pulse and Gray check.
module ptr_sync_gray
    import async_fifo_pkg::*;
#(
    parameter int WIDTH      = PTR_WIDTH_DEFAULT,
    parameter int STAGES     = SYNC_STAGES_DEFAULT,
    parameter int GRAY_CHECK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ptr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sync_ptr,
    output logic [WIDTH-1:0] sync_bin,
    output logic [WIDTH-1:0] ptr_delta,
    output logic             ptr_changed,
    output logic             gray_err
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("ptr_sync_gray: STAGES must be in 2..4");
    end
    if (WIDTH < 2 || WIDTH > PTR_MAX_W) begin : g_bad_width
        $error("ptr_sync_gray: WIDTH must be in 2..16");
    end

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .d   (ptr),
        .q   (sync_ptr)
    );

    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] bin_now;
    logic             violation;

    assign bin_now   = WIDTH'(gray2bin(PTR_MAX_W'(sync_ptr), WIDTH));
    assign violation = (GRAY_CHECK != 0) && popcount_gt1(PTR_MAX_W'(sync_ptr ^ last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last        <= '0;
            sync_bin    <= '0;
            ptr_delta   <= '0;
            ptr_changed <= 1'b0;
            gray_err    <= 1'b0;
        end else begin
            last        <= sync_ptr;
            sync_bin    <= bin_now;
            ptr_delta   <= bin_now - sync_bin;
            ptr_changed <= (sync_ptr != last);
            // A new violation outranks a clear arriving in the same cycle.
            if (violation)
                gray_err <= 1'b1;
            else if (err_clr)
                gray_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Directed bench for ptr_sync_gray: default, STAGES=3 and GRAY_CHECK=0
// instances share the same stimulus.
module tb_ptr_sync_gray;
    import async_fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] ptr;
    logic       err_clr;

    logic [4:0] sp2, sb2, pd2;
    logic       pc2, ge2;
    logic [4:0] sp3, sb3, pd3;
    logic       pc3, ge3;
    logic [4:0] spn, sbn, pdn;
    logic       pcn, gen;

    int checks = 0;
    int errors = 0;

    ptr_sync_gray #(.WIDTH(5), .STAGES(2), .GRAY_CHECK(1)) u_dut (
        .clk(clk), .rst(rst), .ptr(ptr), .err_clr(err_clr),
        .sync_ptr(sp2), .sync_bin(sb2), .ptr_delta(pd2),
        .ptr_changed(pc2), .gray_err(ge2)
    );

    ptr_sync_gray #(.WIDTH(5), .STAGES(3), .GRAY_CHECK(1)) u_dut3 (
        .clk(clk), .rst(rst), .ptr(ptr), .err_clr(err_clr),
        .sync_ptr(sp3), .sync_bin(sb3), .ptr_delta(pd3),
        .ptr_changed(pc3), .gray_err(ge3)
    );

    ptr_sync_gray #(.WIDTH(5), .STAGES(2), .GRAY_CHECK(0)) u_nochk (
        .clk(clk), .rst(rst), .ptr(ptr), .err_clr(err_clr),
        .sync_ptr(spn), .sync_bin(sbn), .ptr_delta(pdn),
        .ptr_changed(pcn), .gray_err(gen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] gptr;
        logic       clr;
        int         edges;
        logic [4:0] bin;
        logic [4:0] delta;
        logic       chg;
        logic       err;
        logic       err_nochk;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] g5(input int b);
        logic [PTR_MAX_W-1:0] t;
        t = bin2gray(PTR_MAX_W'(b % 32), 5);
        return t[4:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " sync_ptr"}, 32'(sp2), 0);
        chk({tag, " sync_bin"}, 32'(sb2), 0);
        chk({tag, " ptr_delta"}, 32'(pd2), 0);
        chk({tag, " ptr_changed"}, 32'(pc2), 0);
        chk({tag, " gray_err"}, 32'(ge2), 0);
        chk({tag, " sync_ptr s3"}, 32'(sp3), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ptr = 5'b0;
        err_clr = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
    endtask

    initial begin
        int pulses;

        // gptr, clr, edges, bin, delta, chg, err, err_nochk
        vecs[0]  = '{5'b00001, 1'b0, 3, 5'd1,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[1]  = '{5'b00011, 1'b0, 3, 5'd2,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{5'b00010, 1'b0, 3, 5'd3,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{5'b00110, 1'b0, 3, 5'd4,  5'd1,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{5'b00101, 1'b0, 3, 5'd6,  5'd2,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{5'b00101, 1'b0, 1, 5'd6,  5'd0,  1'b0, 1'b1, 1'b0};
        vecs[6]  = '{5'b00101, 1'b1, 1, 5'd6,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'b00101, 1'b0, 1, 5'd6,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{5'b00110, 1'b0, 2, 5'd6,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'b00110, 1'b1, 1, 5'd4,  5'd30, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{5'b00110, 1'b1, 1, 5'd4,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{5'b00110, 1'b0, 1, 5'd4,  5'd0,  1'b0, 1'b0, 1'b0};

        // Reset held with a non-zero pointer and a running clock.
        rst = 1'b0;
        ptr = 5'b10110;
        err_clr = 1'b0;
        tick(4);
        chk_all_zero("reset");
        rst = 1'b1;
        ptr = 5'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (pc2 || pc3) pulses++;
        end
        chk("post-reset pulses", 32'(pulses), 0);
        chk_all_zero("post-reset");

        // Latency 0 -> 1 for both chain depths.
        ptr = 5'b00001;
        tick(1);
        chk("lat e1 sync_ptr s2", 32'(sp2), 0);
        tick(1);
        chk("lat e2 sync_ptr s2", 32'(sp2), 1);
        chk("lat e2 sync_ptr s3", 32'(sp3), 0);
        chk("lat e2 changed s2", 32'(pc2), 0);
        tick(1);
        chk("lat e3 sync_bin s2", 32'(sb2), 1);
        chk("lat e3 delta s2", 32'(pd2), 1);
        chk("lat e3 changed s2", 32'(pc2), 1);
        chk("lat e3 sync_ptr s3", 32'(sp3), 1);
        chk("lat e3 changed s3", 32'(pc3), 0);
        tick(1);
        chk("lat e4 changed s2", 32'(pc2), 0);
        chk("lat e4 delta s2", 32'(pd2), 0);
        chk("lat e4 sync_bin s3", 32'(sb3), 1);
        chk("lat e4 delta s3", 32'(pd3), 1);
        chk("lat e4 changed s3", 32'(pc3), 1);
        tick(1);
        chk("lat e5 changed s3", 32'(pc3), 0);

        // Table: legal steps, burst, error clear, coincident set/clear.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            ptr = vecs[v].gptr;
            err_clr = vecs[v].clr;
            tick(vecs[v].edges);
            chk($sformatf("vec%0d sync_bin", v), 32'(sb2), 32'(vecs[v].bin));
            chk($sformatf("vec%0d ptr_delta", v), 32'(pd2), 32'(vecs[v].delta));
            chk($sformatf("vec%0d ptr_changed", v), 32'(pc2), 32'(vecs[v].chg));
            chk($sformatf("vec%0d gray_err", v), 32'(ge2), 32'(vecs[v].err));
            chk($sformatf("vec%0d gray_err nochk", v), 32'(gen), 32'(vecs[v].err_nochk));
        end
        err_clr = 1'b0;

        // Count sequence 0..40 with wrap, one step every 3 cycles.
        do_reset();
        for (int b = 1; b <= 40; b++) begin
            ptr = g5(b);
            tick(3);
            chk($sformatf("count%0d sync_bin", b), 32'(sb2), 32'(b % 32));
            chk($sformatf("count%0d ptr_delta", b), 32'(pd2), 1);
            chk($sformatf("count%0d ptr_changed", b), 32'(pc2), 1);
            chk($sformatf("count%0d gray_err", b), 32'(ge2), 0);
        end

        // Asynchronous reset between edges in the middle of a step.
        ptr = g5(9);
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick(2);
        chk_all_zero("reset held");
        rst = 1'b1;
        tick(3);
        chk("rel sync_bin", 32'(sb2), 9);
        chk("rel ptr_delta", 32'(pd2), 9);
        chk("rel ptr_changed", 32'(pc2), 1);
        chk("rel gray_err", 32'(ge2), 1);
        chk("rel gray_err nochk", 32'(gen), 0);
        tick(1);
        chk("rel+1 ptr_changed", 32'(pc2), 0);
        chk("rel+1 ptr_delta", 32'(pd2), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("rel clr gray_err", 32'(ge2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
